// File: rtl/ddr3_rw_arb.sv
// ddr3_rw_arb -- multi-channel frame-buffer read/write arbiter in front of a MIG
// user interface. It uses round-robin arbitration over one write and one read
// requester per channel. Each channel keeps its own address pointer and
// ping-pong bank. A read-tag FIFO routes returning read data to the channel
// that issued the command.
//
// Ports
//   ui_clk, rst_n            clock, synchronous active-low reset
//   init_calib_complete      MIG calibration done; low parks the FSM in INIT
//   app_rdy, app_wdf_rdy     MIG command / write-data handshake
//   app_rd_data_valid        MIG read data strobe
//   app_en/cmd/addr          MIG command outputs
//   app_wdf_wren/end         MIG write-data strobes (one beat per burst)
//   wr_/rd_addr_min/max      per-channel region bounds (slice i = channel i)
//   wr_/rd_bust_len          per-channel burst length in beats
//   wfifo_rcount             write-FIFO fill levels
//   rfifo_wcount             read-FIFO fill levels
//   wr_load, rd_load         per-channel frame restart (pointer clear)
//   rd_valid                 per-channel read enable
//   pingpang_en              global ping-pong enable
//   wfifo_rden, rfifo_wren   one-hot per-channel FIFO strobes
//   busy, cur_ch, tag_err    status: burst active, granted channel, sticky tag underflow
module ddr3_rw_arb #(
  parameter int CH_NUM    = 2,
  parameter int ADDR_W    = 28,
  parameter int LEN_W     = 8,
  parameter int CNT_W     = 10,
  parameter int ADDR_STEP = 8,
  parameter int PP_BIT    = 26,
  parameter int RF_DEPTH  = 512,
  parameter int TAG_DEPTH = 256,
  localparam int CH_W     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                     ui_clk,
  input  logic                     rst_n,
  input  logic                     init_calib_complete,
  input  logic                     app_rdy,
  input  logic                     app_wdf_rdy,
  input  logic                     app_rd_data_valid,
  output logic                     app_en,
  output logic [2:0]               app_cmd,
  output logic [ADDR_W-1:0]        app_addr,
  output logic                     app_wdf_wren,
  output logic                     app_wdf_end,
  input  logic [CH_NUM*ADDR_W-1:0] wr_addr_min,
  input  logic [CH_NUM*ADDR_W-1:0] wr_addr_max,
  input  logic [CH_NUM*ADDR_W-1:0] rd_addr_min,
  input  logic [CH_NUM*ADDR_W-1:0] rd_addr_max,
  input  logic [CH_NUM*LEN_W-1:0]  wr_bust_len,
  input  logic [CH_NUM*LEN_W-1:0]  rd_bust_len,
  input  logic [CH_NUM*CNT_W-1:0]  wfifo_rcount,
  input  logic [CH_NUM*CNT_W-1:0]  rfifo_wcount,
  input  logic [CH_NUM-1:0]        wr_load,
  input  logic [CH_NUM-1:0]        rd_load,
  input  logic [CH_NUM-1:0]        rd_valid,
  input  logic                     pingpang_en,
  output logic [CH_NUM-1:0]        wfifo_rden,
  output logic [CH_NUM-1:0]        rfifo_wren,
  output logic                     busy,
  output logic [CH_W-1:0]          cur_ch,
  output logic                     tag_err
);

  localparam logic [1:0] INIT  = 2'd0;
  localparam logic [1:0] IDLE  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] READ  = 2'd3;

  localparam int REQ_N  = 2 * CH_NUM;
  localparam int RQ_W   = $clog2(REQ_N);
  localparam int TAG_AW = $clog2(TAG_DEPTH);
  localparam int TAG_CW = TAG_AW + 1;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

  logic [1:0]        state;
  logic [RQ_W-1:0]   last_grant;
  logic              dir;          // 1 = read burst
  logic [LEN_W-1:0]  len_lat;
  logic [LEN_W-1:0]  beat_cnt;
  logic [ADDR_W-1:0] min_lat, max_lat;

  logic [ADDR_W-1:0] wr_ptr [CH_NUM];
  logic [ADDR_W-1:0] rd_ptr [CH_NUM];
  logic [CH_NUM-1:0] wr_bank, rd_bank, wr_pend, rd_pend;

  logic [CH_W-1:0]   tag_mem [TAG_DEPTH];
  logic [TAG_AW-1:0] tag_wp, tag_rp;
  logic [TAG_CW-1:0] tag_cnt;
  logic [CH_W-1:0]   tag_head;
  logic              tag_push, tag_pop;

  logic [REQ_N-1:0]  req;
  logic              grant_found;
  logic [RQ_W-1:0]   grant_idx, cand_idx;
  logic [CH_W-1:0]   grant_ch;
  int                cand;

  logic [ADDR_W-1:0] cur_ptr, base_addr, next_ptr, addr_out;
  logic              cur_bank, wrap_hit, beat, last_beat;

  // Request vector: even index = write of channel gi, odd index = read.
  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_req
    assign req[2*gi] = (wr_bust_len[gi*LEN_W +: LEN_W] != '0) &&
                       (32'(wfifo_rcount[gi*CNT_W +: CNT_W]) >= 32'(wr_bust_len[gi*LEN_W +: LEN_W]));
    assign req[2*gi+1] = rd_valid[gi] && (rd_bust_len[gi*LEN_W +: LEN_W] != '0) &&
                         (32'(rfifo_wcount[gi*CNT_W +: CNT_W]) + 32'(rd_bust_len[gi*LEN_W +: LEN_W])
                          <= 32'(RF_DEPTH)) &&
                         (32'(TAG_DEPTH) - 32'(tag_cnt) >= 32'(rd_bust_len[gi*LEN_W +: LEN_W]));
    assign wfifo_rden[gi] = (state == WRITE) && app_rdy && app_wdf_rdy && (cur_ch == CH_W'(gi));
    assign rfifo_wren[gi] = tag_pop && (tag_head == CH_W'(gi));
  end

  // Round-robin search starting just after the previous winner.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int off = 0; off < REQ_N; off++) begin
      cand     = (int'(last_grant) + 1 + off) % REQ_N;
      cand_idx = RQ_W'(cand);
      if (!grant_found && req[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end
  assign grant_ch = CH_W'(grant_idx >> 1);

  // Beat address and wrap decision for the active channel/direction.
  always_comb begin
    cur_ptr   = dir ? rd_ptr[cur_ch] : wr_ptr[cur_ch];
    cur_bank  = dir ? rd_bank[cur_ch] : wr_bank[cur_ch];
    base_addr = min_lat + cur_ptr;
    wrap_hit  = (base_addr + STEP) >= max_lat;
    next_ptr  = wrap_hit ? '0 : cur_ptr + STEP;
    addr_out  = base_addr;
    addr_out[PP_BIT] = cur_bank & pingpang_en;
  end

  assign busy         = (state == WRITE) || (state == READ);
  assign beat         = ((state == WRITE) && app_rdy && app_wdf_rdy) || ((state == READ) && app_rdy);
  assign last_beat    = beat && (beat_cnt == len_lat - LEN_W'(1));
  assign app_en       = busy;
  assign app_cmd      = (state == READ) ? 3'b001 : 3'b000;
  assign app_addr     = busy ? addr_out : '0;
  assign app_wdf_wren = (state == WRITE);
  assign app_wdf_end  = (state == WRITE);

  always_ff @(posedge ui_clk) begin
    if (!rst_n) begin
      state      <= INIT;
      last_grant <= RQ_W'(REQ_N - 1);
      cur_ch     <= '0;
      dir        <= 1'b0;
      len_lat    <= '0;
      beat_cnt   <= '0;
      min_lat    <= '0;
      max_lat    <= '0;
    end else if (!init_calib_complete) begin
      state <= INIT;
    end else begin
      case (state)
        INIT: state <= IDLE;
        IDLE: if (grant_found) begin
          last_grant <= grant_idx;
          cur_ch     <= grant_ch;
          dir        <= grant_idx[0];
          beat_cnt   <= '0;
          len_lat    <= grant_idx[0] ? rd_bust_len[grant_ch*LEN_W +: LEN_W]
                                     : wr_bust_len[grant_ch*LEN_W +: LEN_W];
          min_lat    <= grant_idx[0] ? rd_addr_min[grant_ch*ADDR_W +: ADDR_W]
                                     : wr_addr_min[grant_ch*ADDR_W +: ADDR_W];
          max_lat    <= grant_idx[0] ? rd_addr_max[grant_ch*ADDR_W +: ADDR_W]
                                     : wr_addr_max[grant_ch*ADDR_W +: ADDR_W];
          state      <= grant_idx[0] ? READ : WRITE;
        end
        WRITE, READ: if (beat) begin
          if (last_beat) state <= IDLE;
          else           beat_cnt <= beat_cnt + LEN_W'(1);
        end
        default: state <= INIT;
      endcase
    end
  end

  // Pointer/bank update. A load that lands mid-burst is parked in *_pend and
  // applied on the final beat (or as soon as the burst is no longer active).
  always_ff @(posedge ui_clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CH_NUM; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      wr_bank <= '0;
      rd_bank <= '0;
      wr_pend <= '0;
      rd_pend <= '0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if ((state == WRITE) && (cur_ch == CH_W'(i))) begin
          if (beat) begin
            wr_ptr[i] <= (last_beat && (wr_pend[i] || wr_load[i])) ? '0 : next_ptr;
            if (wrap_hit && pingpang_en) wr_bank[i] <= ~wr_bank[i];
          end
          if (last_beat)      wr_pend[i] <= 1'b0;
          else if (wr_load[i]) wr_pend[i] <= 1'b1;
        end else if (wr_load[i] || wr_pend[i]) begin
          wr_ptr[i]  <= '0;
          wr_pend[i] <= 1'b0;
        end
        if ((state == READ) && (cur_ch == CH_W'(i))) begin
          if (beat) begin
            rd_ptr[i] <= (last_beat && (rd_pend[i] || rd_load[i])) ? '0 : next_ptr;
            // Read side follows the bank the writer just left.
            if (wrap_hit) rd_bank[i] <= pingpang_en & ~wr_bank[i];
          end
          if (last_beat)      rd_pend[i] <= 1'b0;
          else if (rd_load[i]) rd_pend[i] <= 1'b1;
        end else if (rd_load[i] || rd_pend[i]) begin
          rd_ptr[i]  <= '0;
          rd_pend[i] <= 1'b0;
        end
      end
    end
  end

  // Read-tag FIFO: one entry per issued read beat, popped per returned beat.
  assign tag_push = (state == READ) && app_rdy;
  assign tag_pop  = app_rd_data_valid && (tag_cnt != '0);
  assign tag_head = tag_mem[tag_rp];

  always_ff @(posedge ui_clk) begin
    if (tag_push) tag_mem[tag_wp] <= cur_ch;
  end

  always_ff @(posedge ui_clk) begin
    if (!rst_n) begin
      tag_wp  <= '0;
      tag_rp  <= '0;
      tag_cnt <= '0;
      tag_err <= 1'b0;
    end else begin
      if (tag_push) tag_wp <= (tag_wp == TAG_AW'(TAG_DEPTH - 1)) ? '0 : tag_wp + 1'b1;
      if (tag_pop)  tag_rp <= (tag_rp == TAG_AW'(TAG_DEPTH - 1)) ? '0 : tag_rp + 1'b1;
      case ({tag_push, tag_pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase
      if (app_rd_data_valid && (tag_cnt == '0)) tag_err <= 1'b1;
    end
  end

endmodule
